// File: rtl/sa_allocator.sv
// rtl/sa_allocator.sv - separable input-first switch allocator (VC round-robin, then input round-robin per output)
// Optional per-output grant/conflict counters under `define SA_PERF_CNT_EN.
module sa_allocator #(
  parameter int INPUT_PORT_NUM  = 5,
  parameter int OUTPUT_PORT_NUM = 5,
  parameter int VC_NUM_MAX      = 4,
  parameter int ID_W            = 3
) (
  input  logic                                    clk,
  input  logic                                    rstn,
  input  logic [INPUT_PORT_NUM*VC_NUM_MAX-1:0]      vc_req_i,
  input  logic [INPUT_PORT_NUM*VC_NUM_MAX*ID_W-1:0] vc_req_outport_i,
  input  logic [INPUT_PORT_NUM*VC_NUM_MAX*ID_W-1:0] vc_req_out_vc_id_i,
  input  logic [INPUT_PORT_NUM*VC_NUM_MAX*ID_W-1:0] vc_req_lar_i,
  input  logic [OUTPUT_PORT_NUM-1:0]                outport_ready_i,
  output logic [INPUT_PORT_NUM*VC_NUM_MAX-1:0]      sa_grant_o,
  output logic [INPUT_PORT_NUM-1:0]                 inport_read_enable_st_stage_o,
  output logic [INPUT_PORT_NUM*ID_W-1:0]            inport_read_vc_id_st_stage_o,
  output logic [OUTPUT_PORT_NUM-1:0]                outport_vld_st_stage_o,
  output logic [OUTPUT_PORT_NUM*ID_W-1:0]           outport_select_inport_id_st_stage_o,
  output logic [OUTPUT_PORT_NUM*ID_W-1:0]           outport_vc_id_st_stage_o,
  output logic [OUTPUT_PORT_NUM*ID_W-1:0]           outport_look_ahead_routing_st_stage_o
`ifdef SA_PERF_CNT_EN
  ,
  output logic [OUTPUT_PORT_NUM*32-1:0]             perf_grant_cnt_o,
  output logic [OUTPUT_PORT_NUM*32-1:0]             perf_conflict_cnt_o
`endif
);

  localparam int IP         = INPUT_PORT_NUM;
  localparam int OP         = OUTPUT_PORT_NUM;
  localparam int VC         = VC_NUM_MAX;
  localparam int VC_W       = (VC > 1) ? $clog2(VC) : 1;
  localparam int IP_W       = (IP > 1) ? $clog2(IP) : 1;
  localparam int MESH_PORTS = 4;

  logic [VC-1:0]   mreq     [IP];
  logic [ID_W-1:0] f_op     [IP][VC];
  logic [ID_W-1:0] f_ovc    [IP][VC];
  logic [ID_W-1:0] f_lar    [IP][VC];

  logic [IP-1:0]   cand_vld;
  logic [VC_W-1:0] cand_vc  [IP];
  logic [ID_W-1:0] cand_op  [IP];
  logic [ID_W-1:0] cand_ovc [IP];
  logic [ID_W-1:0] cand_lar [IP];

  logic [OP-1:0]   win_vld;
  logic [OP-1:0]   multi_cand;
  logic [IP_W-1:0] win_in   [OP];
  logic [IP-1:0]   in_won;

  logic [VC_W-1:0] ptr1_q [IP];
  logic [VC_W-1:0] ptr1_d [IP];
  logic [IP_W-1:0] ptr2_q [OP];
  logic [IP_W-1:0] ptr2_d [OP];

  logic [IP-1:0]      rd_en_q, rd_en_d;
  logic [IP*ID_W-1:0] rd_vc_q, rd_vc_d;
  logic [OP-1:0]      vld_q, vld_d;
  logic [OP*ID_W-1:0] sel_q, sel_d;
  logic [OP*ID_W-1:0] ovc_q, ovc_d;
  logic [OP*ID_W-1:0] lar_q, lar_d;

  // An outport id outside the port range matches no ready bit, so it is dropped with the not-ready ones.
  always_comb begin : req_mask
    logic sel_rdy;
    for (int p = 0; p < IP; p++) begin
      mreq[p] = '0;
      for (int v = 0; v < VC; v++) begin
        f_op[p][v]  = vc_req_outport_i[(p*VC+v)*ID_W +: ID_W];
        f_ovc[p][v] = vc_req_out_vc_id_i[(p*VC+v)*ID_W +: ID_W];
        f_lar[p][v] = vc_req_lar_i[(p*VC+v)*ID_W +: ID_W];
        sel_rdy = 1'b0;
        for (int o = 0; o < OP; o++) begin
          if (f_op[p][v] == ID_W'(o)) sel_rdy = outport_ready_i[o];
        end
        mreq[p][v] = vc_req_i[p*VC+v] && sel_rdy &&
                     !(p < MESH_PORTS && f_op[p][v] == ID_W'(p));
      end
    end
  end

  // Downward scan leaves the lowest hit at/above the pointer in hi_v and the lowest overall in lo_v.
  always_comb begin : stage1
    logic hi_f, lo_f;
    int   hi_v, lo_v;
    for (int p = 0; p < IP; p++) begin
      cand_vld[p] = 1'b0;
      cand_vc[p]  = '0;
      cand_op[p]  = '0;
      cand_ovc[p] = '0;
      cand_lar[p] = '0;
      hi_f = 1'b0; lo_f = 1'b0; hi_v = 0; lo_v = 0;
      for (int v = VC-1; v >= 0; v--) begin
        if (mreq[p][v]) begin
          lo_f = 1'b1; lo_v = v;
          if (v >= int'(ptr1_q[p])) begin hi_f = 1'b1; hi_v = v; end
        end
      end
      if (lo_f) begin
        cand_vld[p] = 1'b1;
        cand_vc[p]  = VC_W'(hi_f ? hi_v : lo_v);
        cand_op[p]  = f_op[p][cand_vc[p]];
        cand_ovc[p] = f_ovc[p][cand_vc[p]];
        cand_lar[p] = f_lar[p][cand_vc[p]];
      end
    end
  end

  always_comb begin : stage2
    logic hi_f, lo_f;
    int   hi_p, lo_p;
    for (int o = 0; o < OP; o++) begin
      win_vld[o]    = 1'b0;
      win_in[o]     = '0;
      multi_cand[o] = 1'b0;
      hi_f = 1'b0; lo_f = 1'b0; hi_p = 0; lo_p = 0;
      for (int p = IP-1; p >= 0; p--) begin
        if (cand_vld[p] && cand_op[p] == ID_W'(o)) begin
          if (lo_f) multi_cand[o] = 1'b1;
          lo_f = 1'b1; lo_p = p;
          if (p >= int'(ptr2_q[o])) begin hi_f = 1'b1; hi_p = p; end
        end
      end
      if (lo_f) begin
        win_vld[o] = 1'b1;
        win_in[o]  = IP_W'(hi_f ? hi_p : lo_p);
      end
    end
    for (int p = 0; p < IP; p++) begin
      in_won[p] = 1'b0;
      for (int o = 0; o < OP; o++) begin
        if (win_vld[o] && win_in[o] == IP_W'(p)) in_won[p] = 1'b1;
      end
    end
  end

  always_comb begin : next_state
    sa_grant_o = '0;
    rd_en_d    = '0;
    rd_vc_d    = '0;
    vld_d      = '0;
    sel_d      = '0;
    ovc_d      = '0;
    lar_d      = '0;
    for (int p = 0; p < IP; p++) begin
      ptr1_d[p] = ptr1_q[p];
      if (in_won[p]) begin
        ptr1_d[p]  = (cand_vc[p] == VC_W'(VC-1)) ? '0 : cand_vc[p] + 1'b1;
        rd_en_d[p] = 1'b1;
        rd_vc_d[p*ID_W +: ID_W] = ID_W'(cand_vc[p]);
        for (int v = 0; v < VC; v++) begin
          sa_grant_o[p*VC+v] = (cand_vc[p] == VC_W'(v));
        end
      end
    end
    for (int o = 0; o < OP; o++) begin
      ptr2_d[o] = ptr2_q[o];
      if (win_vld[o]) begin
        ptr2_d[o] = (win_in[o] == IP_W'(IP-1)) ? '0 : win_in[o] + 1'b1;
        vld_d[o]  = 1'b1;
        sel_d[o*ID_W +: ID_W] = ID_W'(win_in[o]);
        ovc_d[o*ID_W +: ID_W] = cand_ovc[win_in[o]];
        lar_d[o*ID_W +: ID_W] = cand_lar[win_in[o]];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_en_q <= '0;
      rd_vc_q <= '0;
      vld_q   <= '0;
      sel_q   <= '0;
      ovc_q   <= '0;
      lar_q   <= '0;
      for (int p = 0; p < IP; p++) ptr1_q[p] <= '0;
      for (int o = 0; o < OP; o++) ptr2_q[o] <= '0;
    end else begin
      rd_en_q <= rd_en_d;
      rd_vc_q <= rd_vc_d;
      vld_q   <= vld_d;
      sel_q   <= sel_d;
      ovc_q   <= ovc_d;
      lar_q   <= lar_d;
      for (int p = 0; p < IP; p++) ptr1_q[p] <= ptr1_d[p];
      for (int o = 0; o < OP; o++) ptr2_q[o] <= ptr2_d[o];
    end
  end

  assign inport_read_enable_st_stage_o         = rd_en_q;
  assign inport_read_vc_id_st_stage_o          = rd_vc_q;
  assign outport_vld_st_stage_o                = vld_q;
  assign outport_select_inport_id_st_stage_o   = sel_q;
  assign outport_vc_id_st_stage_o              = ovc_q;
  assign outport_look_ahead_routing_st_stage_o = lar_q;

`ifdef SA_PERF_CNT_EN
  logic [31:0] grant_cnt_q    [OP];
  logic [31:0] conflict_cnt_q [OP];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int o = 0; o < OP; o++) begin
        grant_cnt_q[o]    <= '0;
        conflict_cnt_q[o] <= '0;
      end
    end else begin
      for (int o = 0; o < OP; o++) begin
        if (win_vld[o] && grant_cnt_q[o] != '1) grant_cnt_q[o] <= grant_cnt_q[o] + 32'd1;
        if (multi_cand[o] && conflict_cnt_q[o] != '1) conflict_cnt_q[o] <= conflict_cnt_q[o] + 32'd1;
      end
    end
  end

  always_comb begin
    for (int o = 0; o < OP; o++) begin
      perf_grant_cnt_o[o*32 +: 32]    = grant_cnt_q[o];
      perf_conflict_cnt_o[o*32 +: 32] = conflict_cnt_q[o];
    end
  end
`else
  logic unused_perf;
  assign unused_perf = ^multi_cand;
`endif

endmodule

// File: tb/tb_sa_allocator.sv
// tb/tb_sa_allocator.sv - table-driven bench for sa_allocator with a queue of expected ST-stage bundles
module tb_sa_allocator;
  localparam int VC = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic [19:0] req;
  logic [59:0] op_i, ovc_i, lar_i;
  logic [4:0]  rdy;
  logic [19:0] grant;
  logic [4:0]  rd_en, vld;
  logic [14:0] rd_vc, sel, ovc_o, lar_o;
`ifdef SA_PERF_CNT_EN
  logic [159:0] pgc, pcc;
`endif

  always #5 clk = ~clk;

  sa_allocator dut (
    .clk                                   (clk),
    .rstn                                  (rstn),
    .vc_req_i                              (req),
    .vc_req_outport_i                      (op_i),
    .vc_req_out_vc_id_i                    (ovc_i),
    .vc_req_lar_i                          (lar_i),
    .outport_ready_i                       (rdy),
    .sa_grant_o                            (grant),
    .inport_read_enable_st_stage_o         (rd_en),
    .inport_read_vc_id_st_stage_o          (rd_vc),
    .outport_vld_st_stage_o                (vld),
    .outport_select_inport_id_st_stage_o   (sel),
    .outport_vc_id_st_stage_o              (ovc_o),
    .outport_look_ahead_routing_st_stage_o (lar_o)
`ifdef SA_PERF_CNT_EN
    ,
    .perf_grant_cnt_o                      (pgc),
    .perf_conflict_cnt_o                   (pcc)
`endif
  );

  typedef struct packed {
    logic [19:0] req;
    logic [59:0] op;
    logic [59:0] ovc;
    logic [59:0] lar;
  } rq_t;

  typedef struct packed {
    logic [4:0]  rd_en;
    logic [14:0] rd_vc;
    logic [4:0]  vld;
    logic [14:0] sel;
    logic [14:0] ovc;
    logic [14:0] lar;
  } st_t;

  typedef struct {
    rq_t         rq;
    logic [4:0]  rdy;
    logic [19:0] eg;
    st_t         es;
  } vec_t;

  st_t   st_act;
  st_t   exp_q[$];
  string nm_q[$];
  int    n_pass = 0;
  int    n_total = 0;
  vec_t  tbl[11];

  assign st_act = {rd_en, rd_vc, vld, sel, ovc_o, lar_o};

  function automatic rq_t rq_add(rq_t r, int p, int v, int op, int ovc, int lar);
    int b = p*VC + v;
    r.req[b]         = 1'b1;
    r.op[b*3 +: 3]   = 3'(op);
    r.ovc[b*3 +: 3]  = 3'(ovc);
    r.lar[b*3 +: 3]  = 3'(lar);
    return r;
  endfunction

  function automatic st_t st_add(st_t s, int o, int p, int v, int ovc, int lar);
    s.rd_en[p]         = 1'b1;
    s.rd_vc[p*3 +: 3]  = 3'(v);
    s.vld[o]           = 1'b1;
    s.sel[o*3 +: 3]    = 3'(p);
    s.ovc[o*3 +: 3]    = 3'(ovc);
    s.lar[o*3 +: 3]    = 3'(lar);
    return s;
  endfunction

  function automatic logic [19:0] g(int p, int v);
    return 20'(1) << (p*VC + v);
  endfunction

  function automatic vec_t mkv(rq_t r, logic [4:0] rd, logic [19:0] eg, st_t es);
    vec_t t;
    t.rq = r; t.rdy = rd; t.eg = eg; t.es = es;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic check_st();
    st_t   e;
    string n;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      chk({n, " st"}, 128'(st_act), 128'(e));
    end
  endtask

  task automatic step(input string nm, input rq_t r, input logic [4:0] rd,
                      input logic [19:0] eg, input st_t es);
    @(negedge clk);
    check_st();
    {req, op_i, ovc_i, lar_i} = r;
    rdy = rd;
    #1;
    chk({nm, " grant"}, 128'(grant), 128'(eg));
    exp_q.push_back(es);
    nm_q.push_back(nm);
  endtask

  task automatic flush();
    @(negedge clk);
    check_st();
    req = '0;
    rdy = '1;
  endtask

  task automatic perf_zero(input string nm);
`ifdef SA_PERF_CNT_EN
    chk({nm, " perf_grant lo"}, pgc[127:0], '0);
    chk({nm, " perf_grant hi"}, 128'(pgc[159:128]), '0);
    chk({nm, " perf_conflict lo"}, pcc[127:0], '0);
    chk({nm, " perf_conflict hi"}, 128'(pcc[159:128]), '0);
`else
    n_total = n_total + 0;
`endif
  endtask

  initial begin
    rq_t r8, cont, rr, ra;
    rstn = 1'b1;
    req = '0; op_i = '0; ovc_i = '0; lar_i = '0; rdy = '1;
    #1 rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset st", 128'(st_act), '0);
    perf_zero("reset");
    rstn = 1'b1;
    @(negedge clk);
    chk("idle after reset st", 128'(st_act), '0);

    r8 = rq_add(rq_add(rq_add('0, 1, 0, 0, 1, 1), 2, 0, 0, 5, 1), 4, 0, 0, 6, 2);
    tbl[0]  = mkv('0, 5'h1f, '0, '0);
    tbl[1]  = mkv(rq_add('0, 2, 1, 0, 2, 3), 5'h1f, g(2, 1), st_add('0, 0, 2, 1, 2, 3));
    tbl[2]  = mkv(rq_add(rq_add('0, 3, 0, 3, 0, 0), 1, 0, 6, 0, 0), 5'h1f, '0, '0);
    tbl[3]  = mkv(rq_add('0, 4, 2, 4, 1, 0), 5'h1f, g(4, 2), st_add('0, 4, 4, 2, 1, 0));
    tbl[4]  = mkv(rq_add(rq_add('0, 0, 0, 1, 0, 0), 2, 0, 3, 1, 2), 5'b11101, g(2, 0),
                  st_add('0, 3, 2, 0, 1, 2));
    tbl[5]  = mkv(rq_add('0, 0, 0, 1, 3, 1), 5'h1f, g(0, 0), st_add('0, 1, 0, 0, 3, 1));
    tbl[6]  = mkv(rq_add(rq_add(rq_add('0, 0, 2, 2, 0, 4), 1, 1, 0, 3, 5), 3, 3, 4, 2, 6), 5'h1f,
                  g(0, 2) | g(1, 1) | g(3, 3),
                  st_add(st_add(st_add('0, 2, 0, 2, 0, 4), 0, 1, 1, 3, 5), 4, 3, 3, 2, 6));
    tbl[7]  = mkv(rq_add(rq_add('0, 1, 0, 2, 1, 1), 1, 3, 3, 2, 2), 5'h1f, g(1, 3),
                  st_add('0, 3, 1, 3, 2, 2));
    tbl[8]  = mkv(r8, 5'h1f, g(2, 0), st_add('0, 0, 2, 0, 5, 1));
    tbl[9]  = mkv(r8, 5'h1f, g(4, 0), st_add('0, 0, 4, 0, 6, 2));
    tbl[10] = mkv(r8, 5'h1f, g(1, 0), st_add('0, 0, 1, 0, 1, 1));

    for (int i = 0; i < 11; i++) begin
      step($sformatf("vec%0d", i), tbl[i].rq, tbl[i].rdy, tbl[i].eg, tbl[i].es);
    end
    flush();

    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;

    rr = '0;
    for (int v = 0; v < 4; v++) rr = rq_add(rr, 4, v, v, v, v + 1);
    for (int k = 0; k < 5; k++) begin
      step($sformatf("vc_rot%0d", k), rr, 5'h1f, g(4, k % 4), st_add('0, k % 4, 4, k % 4, k % 4, k % 4 + 1));
    end

    cont = rq_add(rq_add('0, 0, 0, 2, 1, 1), 4, 0, 2, 3, 0);
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) step($sformatf("contend%0d", k), cont, 5'h1f, g(0, 0), st_add('0, 2, 0, 0, 1, 1));
      else            step($sformatf("contend%0d", k), cont, 5'h1f, g(4, 0), st_add('0, 2, 4, 0, 3, 0));
    end

    ra = '0;
    for (int p = 0; p < 5; p++) ra = rq_add(ra, p, 0, 4, p, p);
    for (int k = 0; k < 6; k++) begin
      step($sformatf("all_to_L%0d", k), ra, 5'h1f, g(k % 5, 0), st_add('0, 4, k % 5, 0, k % 5, k % 5));
    end

    step("mid_burst", cont, 5'h1f, g(0, 0), st_add('0, 2, 0, 0, 1, 1));
    @(negedge clk);
    check_st();
    #2 rstn = 1'b0;
    #1 chk("async reset st", 128'(st_act), '0);
    perf_zero("async reset");
    @(negedge clk);
    chk("reset held st", 128'(st_act), '0);
    req = '0;
    rstn = 1'b1;
    step("post_reset0", cont, 5'h1f, g(0, 0), st_add('0, 2, 0, 0, 1, 1));
    step("post_reset1", cont, 5'h1f, g(4, 0), st_add('0, 2, 4, 0, 3, 0));
    flush();
    @(negedge clk);
    chk("idle end st", 128'(st_act), '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
